// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for ram_arbiter.
// Port I is instruction fetch and port D is load/store; master is the requester side.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [31:0]           i_rdata;
    logic                  i_ready;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [3:0]            d_be;
    logic [31:0]           d_wdata;
    logic [31:0]           d_rdata;
    logic                  d_ready;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
        input  i_rdata, i_ready, d_rdata, d_ready
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
        output i_rdata, i_ready, d_rdata, d_ready
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer that shares the byte-laned Ram between port I and port D.
// Each transaction is IDLE/RESP -> ACCESS (one Ram cycle) -> RESP (ready pulse, lane turnaround).
module ram_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rw,
    output logic                  ram_en1h,
    output logic                  ram_en1l,
    output logic                  ram_en2h,
    output logic                  ram_en2l,
    inout  wire  [7:0]            ram_data1h,
    inout  wire  [7:0]            ram_data1l,
    inout  wire  [7:0]            ram_data2h,
    inout  wire  [7:0]            ram_data2l,
    output logic [1:0]            grant
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    state_t                state_r;
    logic                  last_d_r;
    logic                  owner_d_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  rw_r;
    logic [3:0]            en_r;
    logic [31:0]           wdata_r;
    logic [31:0]           i_rdata_r;
    logic [31:0]           d_rdata_r;
    logic                  i_ready_r;
    logic                  d_ready_r;
    logic [1:0]            grant_r;

    logic                  start_s;
    logic                  pick_d_s;
    logic [3:0]            drive_s;
    logic [31:0]           lanes_s;
    logic [31:0]           rdata_s;

    assign lanes_s = {ram_data1h, ram_data1l, ram_data2h, ram_data2l};
    assign drive_s = ((state_r == ACCESS) && rw_r) ? en_r : 4'b0000;

    assign ram_data1h = drive_s[3] ? wdata_r[31:24] : 8'hzz;
    assign ram_data1l = drive_s[2] ? wdata_r[23:16] : 8'hzz;
    assign ram_data2h = drive_s[1] ? wdata_r[15:8]  : 8'hzz;
    assign ram_data2l = drive_s[0] ? wdata_r[7:0]   : 8'hzz;

    assign ram_addr    = addr_r;
    assign ram_rw      = rw_r;
    assign ram_en1h    = en_r[3];
    assign ram_en1l    = en_r[2];
    assign ram_en2h    = en_r[1];
    assign ram_en2l    = en_r[0];
    assign grant       = grant_r;
    assign bus.i_rdata = i_rdata_r;
    assign bus.i_ready = i_ready_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.d_ready = d_ready_r;

    // Arbitration: in RESP only the port that was not just served may start the next access.
    always_comb begin
        start_s  = 1'b0;
        pick_d_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.i_req && bus.d_req) begin
                    start_s  = 1'b1;
                    pick_d_s = ~last_d_r;
                end else if (bus.i_req) begin
                    start_s  = 1'b1;
                    pick_d_s = 1'b0;
                end else if (bus.d_req) begin
                    start_s  = 1'b1;
                    pick_d_s = 1'b1;
                end else begin
                    start_s  = 1'b0;
                    pick_d_s = 1'b0;
                end
            end
            RESP: begin
                if (owner_d_r) begin
                    start_s  = bus.i_req;
                    pick_d_s = 1'b0;
                end else begin
                    start_s  = bus.d_req;
                    pick_d_s = 1'b1;
                end
            end
            default: begin
                start_s  = 1'b0;
                pick_d_s = 1'b0;
            end
        endcase
    end

    // Read data assembly: disabled lanes and writes return zero bytes.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (!rw_r) begin
            for (int l = 0; l < 4; l++) begin
                rdata_s[8*l +: 8] = en_r[l] ? lanes_s[8*l +: 8] : 8'h00;
            end
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Sequencer FSM with all Ram controls and requester responses registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            last_d_r  <= 1'b1;
            owner_d_r <= 1'b0;
            addr_r    <= '0;
            rw_r      <= 1'b0;
            en_r      <= 4'b0000;
            wdata_r   <= 32'h0000_0000;
            i_rdata_r <= 32'h0000_0000;
            d_rdata_r <= 32'h0000_0000;
            i_ready_r <= 1'b0;
            d_ready_r <= 1'b0;
            grant_r   <= GRANT_NONE;
        end else begin
            i_ready_r <= 1'b0;
            d_ready_r <= 1'b0;
            case (state_r)
                IDLE, RESP: begin
                    if (start_s) begin
                        state_r   <= ACCESS;
                        owner_d_r <= pick_d_s;
                        last_d_r  <= pick_d_s;
                        if (pick_d_s) begin
                            grant_r <= GRANT_D;
                            addr_r  <= bus.d_addr;
                            rw_r    <= bus.d_we;
                            en_r    <= bus.d_be;
                            wdata_r <= bus.d_wdata;
                        end else begin
                            grant_r <= GRANT_I;
                            addr_r  <= bus.i_addr;
                            rw_r    <= 1'b0;
                            en_r    <= 4'b1111;
                            wdata_r <= 32'h0000_0000;
                        end
                    end else begin
                        state_r <= IDLE;
                        grant_r <= GRANT_NONE;
                        rw_r    <= 1'b0;
                        en_r    <= 4'b0000;
                    end
                end
                ACCESS: begin
                    state_r <= RESP;
                    rw_r    <= 1'b0;
                    en_r    <= 4'b0000;
                    if (owner_d_r) begin
                        d_ready_r <= 1'b1;
                        d_rdata_r <= rdata_s;
                    end else begin
                        i_ready_r <= 1'b1;
                        i_rdata_r <= rdata_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= GRANT_NONE;
                    rw_r    <= 1'b0;
                    en_r    <= 4'b0000;
                end
            endcase
        end
    end
endmodule
